// File: rtl/sdram_sched_pkg.sv
// sdram_sched_pkg: shared state encodings, widths and default parameters for the page scheduler
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        W_ACK = 2'd1,
        R_ACK = 2'd2,
        BUSY  = 2'd3
    } sched_state_e;

    localparam int PTR_W  = 15;
    localparam int USED_W = 16;
    localparam int LVL_W  = 11;

    localparam logic [LVL_W-1:0] WR_PRIO_LEVEL = 11'd1536;

    localparam int RING_ROWS_DEF   = 16384;
    localparam int WR_THRESH_DEF   = 512;
    localparam int RD_ROOM_DEF     = 1152;
    localparam int FILL_TRIG_DEF   = 32;
    localparam int ACK_TIMEOUT_DEF = 4096;

endpackage

// File: rtl/sdram_ring_ptr.sv
// sdram_ring_ptr: circular row pointer that advances by one and wraps ROWS-1 back to 0
module sdram_ring_ptr
    import sdram_sched_pkg::*;
#(
    parameter int ROWS = RING_ROWS_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(ROWS - 1);

    logic [PTR_W-1:0] ptr_q;

    // advance on request, wrapping at the end of the ring
    always_ff @(posedge clk_i) begin
        if (!rst_ni) ptr_q <= '0;
        else if (inc_i) ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sdram_page_scheduler.sv
// sdram_page_scheduler: arbitrates page writes and reads over an SDRAM row ring buffer
module sdram_page_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int RING_ROWS   = RING_ROWS_DEF,
    parameter int WR_THRESH   = WR_THRESH_DEF,
    parameter int RD_ROOM     = RD_ROOM_DEF,
    parameter int FILL_TRIG   = FILL_TRIG_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              sdram_clk,
    input  logic              resetin_n,
    input  logic              sdram_wren,
    input  logic              sdram_rden,
    input  logic [LVL_W-1:0]  infifo_level,
    input  logic [LVL_W-1:0]  outfifo_level,
    input  logic              cmd_ack,
    input  logic              cmd_done,
    output logic              cmd_pagewrite,
    output logic              cmd_pageread,
    output logic [PTR_W-1:0]  rowaddr,
    output logic [USED_W-1:0] used_rows,
    output logic              fill_level_trigger,
    output logic              fault_overflow,
    output logic              fault_timeout,
    output logic              busy
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [USED_W-1:0] RING_W  = USED_W'(RING_ROWS);
    localparam logic [USED_W-1:0] FILL_W  = USED_W'(FILL_TRIG);
    localparam logic [LVL_W-1:0]  WR_T    = LVL_W'(WR_THRESH);
    localparam logic [LVL_W-1:0]  RD_T    = LVL_W'(RD_ROOM);

    sched_state_e      state_q;
    logic [PTR_W-1:0]  rowaddr_q, wr_ptr, rd_ptr;
    logic [USED_W-1:0] used_q, used_d;
    logic [CNT_W-1:0]  cnt_q;
    logic last_wr_q, cmd_wr_q, cmd_rd_q, busy_q, fovf_q, fto_q, fill_q;
    logic wr_el, rd_el, ovf, grant_wr, grant_rd, inc_wr, inc_rd;

    // eligibility, arbitration and pointer advance decoded from current state
    always_comb begin
        wr_el    = sdram_wren && infifo_level >= WR_T && used_q < RING_W;
        ovf      = sdram_wren && infifo_level >= WR_T && used_q == RING_W;
        rd_el    = sdram_rden && used_q != '0 && outfifo_level <= RD_T;
        grant_wr = state_q == IDLE && wr_el && (!rd_el || infifo_level >= WR_PRIO_LEVEL || !last_wr_q);
        grant_rd = state_q == IDLE && rd_el && !grant_wr;
        inc_wr   = state_q == W_ACK && cmd_ack;
        inc_rd   = state_q == R_ACK && cmd_ack;
        used_d   = used_q + USED_W'(inc_wr) - USED_W'(inc_rd);
    end

    sdram_ring_ptr #(.ROWS(RING_ROWS)) u_wr_ptr (
        .clk_i (sdram_clk),
        .rst_ni(resetin_n),
        .inc_i (inc_wr),
        .ptr_o (wr_ptr)
    );

    sdram_ring_ptr #(.ROWS(RING_ROWS)) u_rd_ptr (
        .clk_i (sdram_clk),
        .rst_ni(resetin_n),
        .inc_i (inc_rd),
        .ptr_o (rd_ptr)
    );

    // command FSM with registered command, busy, fault and fill outputs
    always_ff @(posedge sdram_clk) begin
        if (!resetin_n) begin
            state_q   <= IDLE;
            rowaddr_q <= '0;
            used_q    <= '0;
            cnt_q     <= '0;
            last_wr_q <= 1'b0;
            cmd_wr_q  <= 1'b0;
            cmd_rd_q  <= 1'b0;
            busy_q    <= 1'b0;
            fovf_q    <= 1'b0;
            fto_q     <= 1'b0;
            fill_q    <= 1'b0;
        end else begin
            used_q <= used_d;
            fill_q <= used_d > FILL_W;
            case (state_q)
                IDLE: begin
                    if (ovf) fovf_q <= 1'b1;
                    if (grant_wr || grant_rd) begin
                        state_q   <= grant_wr ? W_ACK : R_ACK;
                        rowaddr_q <= grant_wr ? wr_ptr : rd_ptr;
                        cmd_wr_q  <= grant_wr;
                        cmd_rd_q  <= grant_rd;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                W_ACK, R_ACK: begin
                    if (cmd_ack) begin
                        state_q   <= BUSY;
                        last_wr_q <= state_q == W_ACK;
                        cmd_wr_q  <= 1'b0;
                        cmd_rd_q  <= 1'b0;
                    end else if (cnt_q == TO_LAST) begin
                        state_q  <= IDLE;
                        fto_q    <= 1'b1;
                        cmd_wr_q <= 1'b0;
                        cmd_rd_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                BUSY: begin
                    if (cmd_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cmd_wr_q <= 1'b0;
                    cmd_rd_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_pagewrite      = cmd_wr_q;
    assign cmd_pageread       = cmd_rd_q;
    assign rowaddr            = rowaddr_q;
    assign used_rows          = used_q;
    assign fill_level_trigger = fill_q;
    assign fault_overflow     = fovf_q;
    assign fault_timeout      = fto_q;
    assign busy               = busy_q;

endmodule

// File: doc/sdram_page_scheduler.md
SDRAM_PAGE_SCHEDULER -- requirements
Module: sdram_page_scheduler

Interface
REQ-001 Parameter RING_ROWS, default 16384: SDRAM rows used as circular buffer, range 2..32768.
REQ-002 Parameter WR_THRESH, default 512: infifo words needed to request a page write.
REQ-003 Parameter RD_ROOM, default 1152: outfifo level at or below which a page read may be requested.
REQ-004 Parameter FILL_TRIG, default 32: used-row count above which fill_level_trigger asserts.
REQ-005 Parameter ACK_TIMEOUT, default 4096: cycles allowed in an ack-wait state.
REQ-006 Port sdram_clk, in, 1: sole clock; all logic on the rising edge.
REQ-007 Port resetin_n, in, 1: reset, synchronous and active-low.
REQ-008 Ports sdram_wren and sdram_rden, in, 1 each: enable page writes and page reads respectively.
REQ-009 Ports infifo_level and outfifo_level, in, 11 each: infifo read-side count and outfifo write-side count.
REQ-010 Ports cmd_ack and cmd_done, in, 1 each: controller accepted the command and finished the page.
REQ-011 Ports cmd_pagewrite and cmd_pageread, out, 1 each: page command requests to the controller.
REQ-012 Port rowaddr, out, 15: row address for the pending command.
REQ-013 Port used_rows, out, 16: pages written but not yet read back.
REQ-014 Port fill_level_trigger, out, 1: high when used_rows > FILL_TRIG.
REQ-015 Ports fault_overflow and fault_timeout, out, 1 each: sticky fault flags.
REQ-016 Port busy, out, 1: high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, W_ACK, R_ACK and BUSY.
REQ-018 In IDLE, write is eligible when sdram_wren=1, infifo_level>=WR_THRESH and used_rows<RING_ROWS.
REQ-019 In IDLE, read is eligible when sdram_rden=1, used_rows>0 and outfifo_level<=RD_ROOM.
REQ-020 When only one request is eligible, it SHALL win.
REQ-021 When both are eligible, arbitration SHALL be round-robin against the last granted type.
REQ-022 Exception to REQ-021: if infifo_level>=1536, write SHALL win.
REQ-023 On a grant, the FSM SHALL capture rowaddr (wr_ptr or rd_ptr) on the same edge and enter W_ACK or R_ACK.
REQ-024 cmd_pagewrite (cmd_pageread) SHALL be registered and high on every cycle the state is W_ACK (R_ACK), and low otherwise.
REQ-025 On cmd_ack=1 in W_ACK or R_ACK, on that edge, the FSM SHALL:
  - increment the matching pointer modulo RING_ROWS, wrapping RING_ROWS-1 to 0;
  - update used_rows by +1 for a write or -1 for a read;
  - record the grant type;
  - enter BUSY.
REQ-026 The command output SHALL deassert on the edge following cmd_ack.
REQ-027 In BUSY, cmd_done=1 SHALL return the FSM to IDLE; cmd_ack in BUSY SHALL be ignored.
REQ-028 A new grant SHALL require at least one cycle in IDLE (minimum command spacing).
REQ-029 An ack-wait counter SHALL reset on entry to W_ACK/R_ACK.
REQ-030 If the counter reaches ACK_TIMEOUT in W_ACK/R_ACK, the FSM SHALL set fault_timeout, return to IDLE and leave pointers and used_rows unchanged.
REQ-031 If sdram_wren=1, infifo_level>=WR_THRESH and used_rows==RING_ROWS in IDLE, fault_overflow SHALL be set and no write granted.
REQ-032 Enables SHALL be sampled only in IDLE; deasserting an enable mid-transaction SHALL not abort it.
REQ-033 The FSM SHALL never enter an unused state; any illegal encoding SHALL go to IDLE.

Reset
REQ-034 While resetin_n=0 at an edge, the next state SHALL be:
  - state IDLE;
  - wr_ptr, rd_ptr, used_rows and rowaddr all 0;
  - command outputs, busy, both faults and fill_level_trigger 0;
  - last grant set to read, so write is favoured first.
REQ-035 Reset mid-transaction SHALL abandon the command immediately; the controller is reset by the same signal.

Structure
REQ-036 State encodings, the 1536 priority threshold and default parameter values SHALL live in shared package sdram_sched_pkg.
REQ-037 The circular pointers SHALL be a sub-module sdram_ring_ptr, instantiated for write and read, with increment-and-wrap.

Verification
REQ-038 Single write: reset, then infifo_level=512 and wren=1 -> W_ACK next edge, rowaddr=0, cmd_pagewrite high until the edge after ack, then used_rows=1 and wr_ptr=1.
REQ-039 Arbitration: both eligible repeatedly with infifo_level=600 -> grants alternate W,R,W,R; with infifo_level=1600 -> all grants are W.
REQ-040 Wrap: RING_ROWS=4, five write/read page pairs -> rowaddr sequence 0,1,2,3,0 for both pointers.
REQ-041 Full: RING_ROWS=4, four writes, no reads, fifth write eligible -> no grant, fault_overflow=1, used_rows=4.
REQ-042 Timeout: ACK_TIMEOUT=8, cmd_ack held low -> fault_timeout=1 after 8 cycles, FSM in IDLE, pointers unchanged.
REQ-043 Reset mid-BUSY -> all outputs 0 on the next edge, and fill_level_trigger=1 only after used_rows reaches 33.
